// File: rtl/adder_bcd_feeder.sv
// -----------------------------------------------------------------------------
// adder_bcd_feeder
//   Upstream stage of the 2-digit seven-segment display driver. Adds two
//   unsigned WIDTH-bit operands plus a carry-in. A sequential shift-add-3
//   (double-dabble) engine then converts the binary sum to two BCD digits.
//   The last result is held steady on o_ones / o_tens so the display never
//   flickers while a new conversion is running.
//
// Parameters
//   WIDTH      operand width, legal range 1..5 (max sum 63 fits two digits)
//
// Ports
//   i_clock    system clock, rising edge
//   i_reset    synchronous, active-high reset
//   i_start    conversion request, only sampled while idle
//   i_op_a     operand A (unsigned, WIDTH bits)
//   i_op_b     operand B (unsigned, WIDTH bits)
//   i_cin      carry-in
//   o_busy     high while a conversion is in progress (SHIFT or DONE)
//   o_done     one-cycle pulse: new o_ones/o_tens/o_sum_bin are valid
//   o_sum_bin  binary sum of the last completed conversion (WIDTH+1 bits)
//   o_ones     BCD units digit of the last sum (display LSD)
//   o_tens     BCD tens digit of the last sum (display MSD)
// -----------------------------------------------------------------------------
module adder_bcd_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH:0]   o_sum_bin,
  output logic [3:0]       o_ones,
  output logic [3:0]       o_tens
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] SHIFTS = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [WIDTH:0] r_bin;      // binary value being shifted out MSB first
  logic [WIDTH:0] r_sum;      // captured sum, published in the DONE cycle
  logic [7:0]     r_scratch;  // {tens, ones} BCD accumulator
  logic [CW-1:0]  r_count;    // shifts remaining

  logic [WIDTH:0] w_sum;
  logic [3:0]     w_lo_adj;
  logic [2:0]     w_hi_adj;
  logic [7:0]     w_scratch_nxt;
  logic           w_last;

  // Full-width sum: zero-extend so the carry-out is kept.
  assign w_sum = {1'b0, i_op_a} + {1'b0, i_op_b} + {{WIDTH{1'b0}}, i_cin};

  // Add-3 correction on each nibble that is 5 or more. The tens nibble only
  // needs its low three bits kept: its shifted value must still fit a digit,
  // and with sums below 64 its top bit is always zero after correction.
  assign w_lo_adj = (r_scratch[3:0] >= 4'd5) ? (r_scratch[3:0] + 4'd3)
                                             : r_scratch[3:0];
  assign w_hi_adj = (r_scratch[7:4] >= 4'd5) ? 3'(r_scratch[7:4] + 4'd3)
                                             : r_scratch[6:4];

  assign w_scratch_nxt = {w_hi_adj, w_lo_adj, r_bin[WIDTH]};
  assign w_last        = (r_count == CW'(1));

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Conversion datapath and held result
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bin     <= '0;
      r_sum     <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      o_sum_bin <= '0;
      o_ones    <= '0;
      o_tens    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin     <= w_sum;
            r_sum     <= w_sum;
            r_scratch <= '0;
            r_count   <= SHIFTS;
          end
        end
        SHIFT: begin
          r_scratch <= w_scratch_nxt;
          r_bin     <= {r_bin[WIDTH-1:0], 1'b0};
          r_count   <= r_count - CW'(1);
          // The result registers load on the edge that enters DONE, so the
          // new digits are already on the outputs while o_done is high.
          if (w_last) begin
            o_ones    <= w_scratch_nxt[3:0];
            o_tens    <= w_scratch_nxt[7:4];
            o_sum_bin <= r_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
